sdram_responder: RTL and testbench
==================================

SDRAM_RESPONDER -- requirements
Module: sdram_responder

Interface
REQ-001 Parameters SHALL be:
- ROW_BITS, 2, row-address LSBs kept per bank.
- REF_LIMIT, 1024, maximum cycles allowed between REFRESH commands.
- TRFC, 7, busy cycles after REFRESH.
REQ-002 Ports SHALL be:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- sdram_cle  in  1  clock enable.
- sdram_cs, sdram_ras, sdram_cas, sdram_we  in  1 each  command strobes.
- sdram_dqm  in  1  data mask.
- sdram_ba  in  2  bank address.
- sdram_a  in  13  row address or column address.
- sdram_dqi  in  32  write data from the controller.
- sdram_dqo  out  32  read data to the controller.
- dqo_en  out  1  high while sdram_dqo carries a valid beat.
- err  out  4  sticky protocol-error flags.

Function
REQ-003 Command decode SHALL use {cs,ras,cas,we}:
- 1xxx deselect, 0111 NOP, 0011 ACTIVE, 0101 READ, 0100 WRITE.
- 0110 TERMINATE, 0010 PRECHARGE, 0001 REFRESH, 0000 LOAD_MODE.
REQ-004 While sdram_cle=0, the block SHALL ignore commands and freeze the read pipeline and all counters except the refresh-interval counter.
REQ-005 LOAD_MODE SHALL latch CL=a[6:4] (only 2 or 3 legal) and BL=a[2:0] (000/001/010/011 = 1/2/4/8) and set mode_loaded.
REQ-006 ACTIVE SHALL open bank ba with row a[ROW_BITS-1:0]. ACTIVE to an already-open bank SHALL set err[0] and be ignored.
REQ-007 PRECHARGE SHALL close bank ba, or close all banks when a[10]=1.
REQ-008 The column SHALL be a[9:2]. The storage word index SHALL be {ba, open_row[ba], col}, giving 2^(ROW_BITS+10) x 32 words.
REQ-009 WRITE SHALL store sdram_dqi at the edge where the command is sampled, unless sdram_dqm=1. Write burst length SHALL always be 1.
REQ-010 READ sampled at edge N SHALL start a burst of BL beats:
- Beat k is fetched at edge N+k.
- The column wraps within the BL-aligned block (sequential order).
- Beat k is driven on sdram_dqo with dqo_en=1 so that it is correctly sampled at edge N+CL+k.
REQ-011 If sdram_dqm=1 at the fetch edge of a beat, that beat SHALL drive sdram_dqo=0 with dqo_en=0.
REQ-012 When no beat is valid, sdram_dqo SHALL be 0 and dqo_en SHALL be 0 (no tristate).
REQ-013 A new READ SHALL cancel unfetched beats of the previous burst. Beats already fetched SHALL still be delivered, so back-to-back READs give contiguous data.
REQ-014 WRITE, TERMINATE, or PRECHARGE of the bursting bank SHALL cancel unfetched beats.
REQ-015 A READ or WRITE to a closed bank SHALL set err[0] and have no effect.
REQ-016 A READ, WRITE, or ACTIVE before mode_loaded SHALL set err[1] and be ignored.
REQ-017 REFRESH with all banks closed SHALL start a TRFC-cycle busy window. Any command other than NOP/deselect inside the window SHALL set err[2].
REQ-018 REFRESH with any bank open SHALL set err[0].
REQ-019 A refresh-interval counter SHALL clear on REFRESH and saturate at REF_LIMIT. Reaching REF_LIMIT SHALL set err[3].
REQ-020 err bits SHALL be sticky and clear only on reset.

Reset
REQ-021 Asserting rst SHALL asynchronously set:
- all banks closed, mode_loaded=0, CL=2, BL=1;
- read pipeline and burst state cleared;
- refresh counters cleared;
- sdram_dqo=0, dqo_en=0, err=0.
REQ-022 Storage contents SHALL NOT be reset.
REQ-023 Reset asserted mid-burst SHALL drop all beats; dqo_en SHALL be 0 from the reset edge.

Structure
REQ-024 Command encodings, mode-field bit positions, and CL/BL codes SHALL live in shared package sdram_pkg, which the controller also uses.
REQ-025 Storage SHALL be sub-module sdram_resp_mem: 1 write port, 1 read port, synchronous write, combinational read.

Verification
REQ-026 LOAD_MODE a=0x022, ACTIVE ba=1 row=3, WRITE col=5 data=0xA5A5_0001, READ col=5 -> 0xA5A5_0001 sampled at edge N+2.
REQ-027 LOAD_MODE a=0x032 (CL=3, BL=4), write cols 4..7 = 1,2,3,4, READ col=6 -> beats 3,4,1,2 at edges N+3..N+6.
REQ-028 READ col=0 then READ col=8 one cycle later (BL=4) -> beat from col 0, then col-8 burst with no gap; remaining col-0 beats dropped.
REQ-029 READ to closed bank 2 -> err=0001, dqo_en stays 0. WRITE before LOAD_MODE -> err[1]=1.
REQ-030 REFRESH, then ACTIVE 3 cycles later -> err[2]=1. No REFRESH for 1024 cycles -> err[3]=1.
REQ-031 Assert rst during the second beat of a BL=8 burst -> dqo_en=0 and err=0 immediately; a write/read issued after re-init returns the correct data.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions for the controller and the responder model.
// Contents: command encoding on {cs, ras, cas, we}, mode-register field positions,
// CAS-latency and burst-length codes, and decode helpers.
package sdram_pkg;

  // Deselect is any command with cs high. It is folded onto one code so the decode has a
  // single value for "no command".
  typedef enum logic [3:0] {
    CmdLoadMode  = 4'b0000,
    CmdRefresh   = 4'b0001,
    CmdPrecharge = 4'b0010,
    CmdActive    = 4'b0011,
    CmdWrite     = 4'b0100,
    CmdRead      = 4'b0101,
    CmdTerminate = 4'b0110,
    CmdNop       = 4'b0111,
    CmdDeselect  = 4'b1000
  } sdram_cmd_e;

  // Address-bus field positions.
  localparam int unsigned ModeClLsb    = 4;
  localparam int unsigned ModeClMsb    = 6;
  localparam int unsigned ModeBlLsb    = 0;
  localparam int unsigned ModeBlMsb    = 2;
  localparam int unsigned AddrColLsb   = 2;
  localparam int unsigned AddrColMsb   = 9;
  localparam int unsigned AddrAllBanks = 10;

  // CAS latency codes (only these two are legal).
  localparam logic [2:0] ClCode2 = 3'd2;
  localparam logic [2:0] ClCode3 = 3'd3;

  // Burst length codes.
  localparam logic [2:0] BlCode1 = 3'd0;
  localparam logic [2:0] BlCode2 = 3'd1;
  localparam logic [2:0] BlCode4 = 3'd2;
  localparam logic [2:0] BlCode8 = 3'd3;

  function automatic sdram_cmd_e decode_cmd(input logic cs, input logic ras, input logic cas,
                                            input logic we);
    if (cs) return CmdDeselect;
    return sdram_cmd_e'({1'b0, ras, cas, we});
  endfunction

  // Returns burst length minus one, which doubles as the column wrap mask.
  function automatic logic [2:0] burst_mask(input logic [2:0] bl_code);
    case (bl_code)
      BlCode1: return 3'd0;
      BlCode2: return 3'd1;
      BlCode4: return 3'd3;
      BlCode8: return 3'd7;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/sdram_resp_mem.sv
// Backing store for the SDRAM responder.
// Ports: clk_i clock; we_i/waddr_i/wdata_i synchronous write port;
// raddr_i/rdata_o combinational read port. Contents are never reset.
module sdram_resp_mem #(
  parameter int unsigned AddrW = 12,
  parameter int unsigned DataW = 32
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [DataW-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [DataW-1:0] rdata_o
);

  logic [DataW-1:0] mem_q [2**AddrW];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sdram_responder.sv
// Behavioural SDRAM device model used to answer an SDRAM controller.
// Ports: clk/rst clock and async active-high reset; sdram_cle clock enable;
// sdram_cs/ras/cas/we command strobes; sdram_dqm data mask; sdram_ba bank; sdram_a address;
// sdram_dqi write data; sdram_dqo/dqo_en read data and its valid; err sticky error flags
// (0: bank state, 1: command before mode load, 2: command inside refresh window,
// 3: refresh interval exceeded).
module sdram_responder
  import sdram_pkg::*;
#(
  parameter int unsigned ROW_BITS  = 2,
  parameter int unsigned REF_LIMIT = 1024,
  parameter int unsigned TRFC      = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sdram_cle,
  input  logic        sdram_cs,
  input  logic        sdram_ras,
  input  logic        sdram_cas,
  input  logic        sdram_we,
  input  logic        sdram_dqm,
  input  logic [1:0]  sdram_ba,
  input  logic [12:0] sdram_a,
  input  logic [31:0] sdram_dqi,
  output logic [31:0] sdram_dqo,
  output logic        dqo_en,
  output logic [3:0]  err
);

  localparam int unsigned AddrW = ROW_BITS + 10;
  localparam int unsigned RefW  = $clog2(REF_LIMIT + 1);
  localparam int unsigned BusyW = $clog2(TRFC + 1);
  localparam logic [RefW-1:0]  RefLimit = RefW'(REF_LIMIT);
  localparam logic [BusyW-1:0] BusyInit = BusyW'(TRFC);

  // Bank / mode / error state
  logic [3:0]                 open_q, open_d;
  logic [3:0][ROW_BITS-1:0]   row_q, row_d;
  logic                       mode_q, mode_d;
  logic                       cl3_q, cl3_d;
  logic [2:0]                 bl_q, bl_d;
  logic [3:0]                 err_q, err_d;
  logic [BusyW-1:0]           busy_q, busy_d;
  logic [RefW-1:0]            ref_cnt_q, ref_cnt_d;
  // Burst state: beats still to fetch, next beat index, wrap mask and start address
  logic [2:0]                 burst_left_q, burst_left_d;
  logic [2:0]                 burst_k_q, burst_k_d;
  logic [2:0]                 burst_mask_q, burst_mask_d;
  logic [1:0]                 burst_ba_q, burst_ba_d;
  logic [ROW_BITS-1:0]        burst_row_q, burst_row_d;
  logic [7:0]                 burst_col_q, burst_col_d;
  // Read pipeline between fetch and the output register
  logic                       p1_vld_q, p1_vld_d, p2_vld_q, p2_vld_d;
  logic [31:0]                p1_dat_q, p1_dat_d, p2_dat_q, p2_dat_d;
  logic [31:0]                dqo_q, dqo_d;
  logic                       dqo_en_q, dqo_en_d;

  sdram_cmd_e          cmd;
  logic [1:0]          ba;
  logic [7:0]          col, bcol;
  logic                busy, is_cmd, in_window, accept;
  logic                rd_go, wr_go, cancel, burst_fetch, fetch_vld;
  logic [31:0]         fetch_dat, rdata;
  logic [AddrW-1:0]    waddr, raddr;
  logic                unused_addr;

  assign cmd       = decode_cmd(sdram_cs, sdram_ras, sdram_cas, sdram_we);
  assign ba        = sdram_ba;
  assign col       = sdram_a[AddrColMsb:AddrColLsb];
  assign busy      = busy_q != '0;
  assign is_cmd    = sdram_cle && (cmd != CmdNop) && (cmd != CmdDeselect);
  assign in_window = is_cmd && busy;
  assign accept    = is_cmd && !busy;

  assign rd_go = accept && (cmd == CmdRead) && mode_q && open_q[ba];
  assign wr_go = accept && (cmd == CmdWrite) && mode_q && open_q[ba];

  assign cancel = wr_go || (accept && (cmd == CmdTerminate)) ||
                  (accept && (cmd == CmdPrecharge) &&
                   (sdram_a[AddrAllBanks] || (ba == burst_ba_q)));

  assign burst_fetch = sdram_cle && (burst_left_q != 3'd0) && !cancel && !rd_go;

  // Sequential wrap inside the BL-aligned block
  assign bcol = (burst_col_q & ~{5'b0, burst_mask_q}) |
                ((burst_col_q + {5'b0, burst_k_q}) & {5'b0, burst_mask_q});

  assign waddr = {ba, row_q[ba], col};
  assign raddr = rd_go ? {ba, row_q[ba], col} : {burst_ba_q, burst_row_q, bcol};

  assign fetch_vld = (rd_go || burst_fetch) && !sdram_dqm;
  assign fetch_dat = fetch_vld ? rdata : 32'd0;

  assign unused_addr = ^sdram_a[12:11];

  sdram_resp_mem #(
    .AddrW(AddrW),
    .DataW(32)
  ) u_mem (
    .clk_i  (clk),
    .we_i   (wr_go && !sdram_dqm),
    .waddr_i(waddr),
    .wdata_i(sdram_dqi),
    .raddr_i(raddr),
    .rdata_o(rdata)
  );

  always_comb begin
    open_d       = open_q;
    row_d        = row_q;
    mode_d       = mode_q;
    cl3_d        = cl3_q;
    bl_d         = bl_q;
    err_d        = err_q;
    busy_d       = busy_q;
    ref_cnt_d    = ref_cnt_q;
    burst_left_d = burst_left_q;
    burst_k_d    = burst_k_q;
    burst_mask_d = burst_mask_q;
    burst_ba_d   = burst_ba_q;
    burst_row_d  = burst_row_q;
    burst_col_d  = burst_col_q;
    p1_vld_d     = p1_vld_q;
    p1_dat_d     = p1_dat_q;
    p2_vld_d     = p2_vld_q;
    p2_dat_d     = p2_dat_q;
    dqo_d        = dqo_q;
    dqo_en_d     = dqo_en_q;

    // The refresh-interval counter keeps running while the clock enable is low.
    if (ref_cnt_q != RefLimit) ref_cnt_d = ref_cnt_q + RefW'(1);

    if (sdram_cle) begin
      if (busy) busy_d = busy_q - BusyW'(1);

      if (in_window) begin
        err_d[2] = 1'b1;
      end else if (is_cmd) begin
        case (cmd)
          CmdLoadMode: begin
            mode_d = 1'b1;
            if (sdram_a[ModeClMsb:ModeClLsb] == ClCode2) cl3_d = 1'b0;
            else if (sdram_a[ModeClMsb:ModeClLsb] == ClCode3) cl3_d = 1'b1;
            if (!sdram_a[ModeBlMsb]) bl_d = sdram_a[ModeBlMsb:ModeBlLsb];
          end
          CmdActive: begin
            if (!mode_q) err_d[1] = 1'b1;
            else if (open_q[ba]) err_d[0] = 1'b1;
            else begin
              open_d[ba] = 1'b1;
              row_d[ba]  = sdram_a[ROW_BITS-1:0];
            end
          end
          CmdRead, CmdWrite: begin
            if (!mode_q) err_d[1] = 1'b1;
            else if (!open_q[ba]) err_d[0] = 1'b1;
          end
          CmdPrecharge: begin
            if (sdram_a[AddrAllBanks]) open_d = '0;
            else open_d[ba] = 1'b0;
          end
          CmdRefresh: begin
            if (|open_q) err_d[0] = 1'b1;
            else begin
              busy_d    = BusyInit;
              ref_cnt_d = '0;
            end
          end
          default: ;
        endcase
      end

      if (rd_go) begin
        burst_left_d = burst_mask(bl_q);
        burst_mask_d = burst_mask(bl_q);
        burst_k_d    = 3'd1;
        burst_ba_d   = ba;
        burst_row_d  = row_q[ba];
        burst_col_d  = col;
      end else if (cancel) begin
        burst_left_d = 3'd0;
      end else if (burst_fetch) begin
        burst_left_d = burst_left_q - 3'd1;
        burst_k_d    = burst_k_q + 3'd1;
      end

      // A fetched beat needs CL-1 further edges before it is on the pins.
      dqo_d    = p2_dat_q;
      dqo_en_d = p2_vld_q;
      if (cl3_q) begin
        p2_vld_d = p1_vld_q;
        p2_dat_d = p1_dat_q;
        p1_vld_d = fetch_vld;
        p1_dat_d = fetch_dat;
      end else begin
        p2_vld_d = fetch_vld;
        p2_dat_d = fetch_dat;
        p1_vld_d = 1'b0;
        p1_dat_d = 32'd0;
      end
    end

    if (ref_cnt_d == RefLimit) err_d[3] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      open_q       <= '0;
      row_q        <= '0;
      mode_q       <= 1'b0;
      cl3_q        <= 1'b0;
      bl_q         <= BlCode1;
      err_q        <= '0;
      busy_q       <= '0;
      ref_cnt_q    <= '0;
      burst_left_q <= '0;
      burst_k_q    <= '0;
      burst_mask_q <= '0;
      burst_ba_q   <= '0;
      burst_row_q  <= '0;
      burst_col_q  <= '0;
      p1_vld_q     <= 1'b0;
      p1_dat_q     <= '0;
      p2_vld_q     <= 1'b0;
      p2_dat_q     <= '0;
      dqo_q        <= '0;
      dqo_en_q     <= 1'b0;
    end else begin
      open_q       <= open_d;
      row_q        <= row_d;
      mode_q       <= mode_d;
      cl3_q        <= cl3_d;
      bl_q         <= bl_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
      ref_cnt_q    <= ref_cnt_d;
      burst_left_q <= burst_left_d;
      burst_k_q    <= burst_k_d;
      burst_mask_q <= burst_mask_d;
      burst_ba_q   <= burst_ba_d;
      burst_row_q  <= burst_row_d;
      burst_col_q  <= burst_col_d;
      p1_vld_q     <= p1_vld_d;
      p1_dat_q     <= p1_dat_d;
      p2_vld_q     <= p2_vld_d;
      p2_dat_q     <= p2_dat_d;
      dqo_q        <= dqo_d;
      dqo_en_q     <= dqo_en_d;
    end
  end

  assign sdram_dqo = dqo_q;
  assign dqo_en    = dqo_en_q;
  assign err       = err_q;

endmodule

// File: tb/tb_sdram_responder.sv
// Scoreboard bench for sdram_responder: the stimulus thread pushes expected read beats
// (edge number + data); a monitor samples on the falling edge and pops/compares each beat.
module tb_sdram_responder;

  localparam logic [3:0] C_LMR = 4'b0000;
  localparam logic [3:0] C_REF = 4'b0001;
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_WR  = 4'b0100;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_NOP = 4'b0111;

  typedef struct {
    int          edge_n;
    logic [31:0] data;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cle = 1'b1;
  logic        cs = 1'b0, ras = 1'b1, cas = 1'b1, we = 1'b1;
  logic        dqm = 1'b0;
  logic [1:0]  ba = '0;
  logic [12:0] a = '0;
  logic [31:0] dqi = '0;
  logic [31:0] dqo;
  logic        dqo_en;
  logic [3:0]  err;

  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;
  beat_t exp_q[$];

  sdram_responder dut (
    .clk      (clk),
    .rst      (rst),
    .sdram_cle(cle),
    .sdram_cs (cs),
    .sdram_ras(ras),
    .sdram_cas(cas),
    .sdram_we (we),
    .sdram_dqm(dqm),
    .sdram_ba (ba),
    .sdram_a  (a),
    .sdram_dqi(dqi),
    .sdram_dqo(dqo),
    .dqo_en   (dqo_en),
    .err      (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Drives one command for one edge; n is the number of the edge that samples it.
  task automatic issue(input logic [3:0] c, input logic [1:0] b, input logic [12:0] addr,
                       input logic [31:0] d, input logic m, output int n);
    @(negedge clk);
    {cs, ras, cas, we} = c;
    ba  = b;
    a   = addr;
    dqi = d;
    dqm = m;
    n   = cyc + 1;
    @(posedge clk);
    #1;
    {cs, ras, cas, we} = C_NOP;
    ba  = '0;
    a   = '0;
    dqi = '0;
    dqm = 1'b0;
  endtask

  task automatic push(input int e, input logic [31:0] d);
    beat_t b;
    b.edge_n = e;
    b.data   = d;
    exp_q.push_back(b);
  endtask

  task automatic nop(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic monitor();
    beat_t b;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (dqo_en) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL beat_unexpected: got dqo=%h for edge %0d, required no beat", dqo,
                     cyc + 1);
          end else begin
            b = exp_q.pop_front();
            if (b.edge_n != cyc + 1 || b.data !== dqo) begin
              errors++;
              $display("FAIL beat: got %h at edge %0d, required %h at edge %0d", dqo, cyc + 1,
                       b.data, b.edge_n);
            end
          end
        end else begin
          checks++;
          if (dqo !== 32'd0) begin
            errors++;
            $display("FAIL idle_dqo: got %h, required 00000000", dqo);
          end
          if (exp_q.size() > 0 && exp_q[0].edge_n <= cyc + 1) begin
            b = exp_q.pop_front();
            errors++;
            $display("FAIL beat_missing: got no beat at edge %0d, required %h", cyc + 1, b.data);
          end
        end
      end
    end
  endtask

  initial begin
    int n, n2;
    fork
      monitor();
    join_none

    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_err", {28'd0, err}, 32'd0);
    chk("reset_dqo_en", {31'd0, dqo_en}, 32'd0);
    chk("reset_dqo", dqo, 32'd0);

    // Write before LOAD_MODE
    issue(C_WR, 2'd0, 13'd0, 32'h1234_5678, 1'b0, n);
    chk("write_before_mode", {28'd0, err}, 32'h2);
    do_reset();
    #1;
    chk("err_cleared_by_reset", {28'd0, err}, 32'd0);

    // CL=2 BL=4, single visible beat; later beats masked by dqm
    issue(C_LMR, 2'd0, 13'h022, 32'd0, 1'b0, n);
    issue(C_ACT, 2'd1, 13'd3, 32'd0, 1'b0, n);
    issue(C_WR, 2'd1, 13'(5 << 2), 32'hA5A5_0001, 1'b0, n);
    issue(C_RD, 2'd1, 13'(5 << 2), 32'd0, 1'b0, n);
    push(n + 2, 32'hA5A5_0001);
    repeat (3) issue(C_NOP, 2'd0, 13'd0, 32'd0, 1'b1, n2);
    nop(4);

    // Masked write must not store
    issue(C_WR, 2'd1, 13'(5 << 2), 32'hDEAD_BEEF, 1'b1, n);
    issue(C_RD, 2'd1, 13'(5 << 2), 32'd0, 1'b0, n);
    push(n + 2, 32'hA5A5_0001);
    repeat (3) issue(C_NOP, 2'd0, 13'd0, 32'd0, 1'b1, n2);
    nop(4);

    // ACTIVE to an open bank with clock enable low is ignored
    @(negedge clk);
    cle = 1'b0;
    issue(C_ACT, 2'd1, 13'd3, 32'd0, 1'b0, n);
    cle = 1'b1;
    chk("cle_low_ignored", {28'd0, err}, 32'd0);

    // CL=3 BL=4 wrapping burst
    issue(C_LMR, 2'd0, 13'h032, 32'd0, 1'b0, n);
    for (int i = 0; i < 4; i++) issue(C_WR, 2'd1, 13'((4 + i) << 2), 32'(i + 1), 1'b0, n);
    issue(C_RD, 2'd1, 13'(6 << 2), 32'd0, 1'b0, n);
    push(n + 3, 32'd3);
    push(n + 4, 32'd4);
    push(n + 5, 32'd1);
    push(n + 6, 32'd2);
    nop(8);

    // Back-to-back READs: one beat of col 0, then the whole col 8 burst
    for (int i = 0; i < 4; i++) begin
      issue(C_WR, 2'd1, 13'(i << 2), 32'h20 + 32'(i), 1'b0, n);
      issue(C_WR, 2'd1, 13'((8 + i) << 2), 32'h10 + 32'(i), 1'b0, n);
    end
    issue(C_RD, 2'd1, 13'd0, 32'd0, 1'b0, n);
    issue(C_RD, 2'd1, 13'(8 << 2), 32'd0, 1'b0, n2);
    push(n + 3, 32'h20);
    for (int k = 0; k < 4; k++) push(n2 + 3 + k, 32'h10 + 32'(k));
    nop(10);
    chk("no_err_after_bursts", {28'd0, err}, 32'd0);

    // READ to closed bank
    issue(C_RD, 2'd2, 13'd0, 32'd0, 1'b0, n);
    nop(6);
    chk("read_closed_bank", {28'd0, err}, 32'h1);

    // Refresh window boundary, then REFRESH with an open bank
    do_reset();
    issue(C_LMR, 2'd0, 13'h020, 32'd0, 1'b0, n);
    issue(C_REF, 2'd0, 13'd0, 32'd0, 1'b0, n);
    nop(7);
    issue(C_ACT, 2'd0, 13'd0, 32'd0, 1'b0, n);
    chk("act_after_trfc", {28'd0, err}, 32'd0);
    issue(C_REF, 2'd0, 13'd0, 32'd0, 1'b0, n);
    chk("refresh_bank_open", {28'd0, err}, 32'h1);
    do_reset();
    issue(C_REF, 2'd0, 13'd0, 32'd0, 1'b0, n);
    nop(2);
    issue(C_ACT, 2'd0, 13'd0, 32'd0, 1'b0, n);
    chk("act_in_refresh_window", {28'd0, err}, 32'h4);

    // Refresh interval
    do_reset();
    nop(1000);
    chk("ref_interval_below", {28'd0, err}, 32'd0);
    nop(30);
    chk("ref_interval_expired", {28'd0, err}, 32'h8);

    // Reset during the second beat of a BL=8 burst
    do_reset();
    issue(C_LMR, 2'd0, 13'h023, 32'd0, 1'b0, n);
    issue(C_ACT, 2'd0, 13'd0, 32'd0, 1'b0, n);
    for (int i = 0; i < 8; i++) issue(C_WR, 2'd0, 13'(i << 2), 32'h100 + 32'(i), 1'b0, n);
    issue(C_ACT, 2'd0, 13'd0, 32'd0, 1'b0, n);
    chk("act_open_bank", {28'd0, err}, 32'h1);
    issue(C_RD, 2'd0, 13'd0, 32'd0, 1'b0, n);
    for (int k = 0; k < 8; k++) push(n + 2 + k, 32'h100 + 32'(k));
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midburst_reset_dqo_en", {31'd0, dqo_en}, 32'd0);
    chk("midburst_reset_err", {28'd0, err}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    issue(C_LMR, 2'd0, 13'h020, 32'd0, 1'b0, n);
    issue(C_ACT, 2'd0, 13'd0, 32'd0, 1'b0, n);
    issue(C_WR, 2'd0, 13'(3 << 2), 32'hCAFE_0003, 1'b0, n);
    issue(C_RD, 2'd0, 13'(3 << 2), 32'd0, 1'b0, n);
    push(n + 2, 32'hCAFE_0003);
    nop(5);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
